cordic_phase_demod: RTL and testbench

Iterative vectoring-mode CORDIC that sits directly downstream of the IQ demodulator. It converts each baseband (I_BB, Q_BB) sample into a phase angle and a scaled magnitude. It also outputs the wrapped phase difference between consecutive samples (instantaneous frequency), which the downstream O-QPSK/MSK symbol decision stage consumes. One sample is accepted every ITER+1 clocks, which matches the demodulator's one-valid-in-5-clocks rate at the default ITER=4.

---
 rtl/cordic_phase_demod_if.sv | 29 ++
 rtl/cordic_phase_demod.sv | 163 ++++++++++++++++
 tb/tb_cordic_phase_demod.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_phase_demod_if.sv
// cordic_phase_demod_if: sample-in / result-out bundle between the IQ demodulator, the CORDIC and the symbol decision stage.
// Latency: none (wires only).
// No backpressure: the producer strobes demod_iq_valid and the consumer watches cordic_valid and overrun_o.
interface cordic_phase_demod_if #(
  parameter int IN_W    = 5,
  parameter int PHASE_W = 8
);
  logic                      demod_iq_valid;
  logic signed [IN_W-1:0]    I_BB;
  logic signed [IN_W-1:0]    Q_BB;
  logic                      cordic_valid;
  logic signed [PHASE_W-1:0] phase_o;
  logic signed [PHASE_W-1:0] freq_o;
  logic [IN_W+1:0]           mag_o;
  logic                      busy_o;
  logic                      overrun_o;

  // Demodulator side: drives samples, observes results.
  modport master (
    output demod_iq_valid, I_BB, Q_BB,
    input  cordic_valid, phase_o, freq_o, mag_o, busy_o, overrun_o
  );

  // CORDIC side: consumes samples, produces results.
  modport slave (
    input  demod_iq_valid, I_BB, Q_BB,
    output cordic_valid, phase_o, freq_o, mag_o, busy_o, overrun_o
  );
endinterface

// File: rtl/cordic_phase_demod.sv
// cordic_phase_demod: iterative vectoring CORDIC giving phase, scaled magnitude and wrapped phase step per IQ sample.
// Latency: ITER clocks from the accepted valid edge to the result edge; throughput one sample per ITER+1 clocks.
// No backpressure: a valid seen while busy is dropped and latches the sticky overrun_o flag.
module cordic_phase_demod #(
  parameter int IN_W    = 5,
  parameter int PHASE_W = 8,   // atan table is derived from 16-bit-circle values, so keep PHASE_W <= 15
  parameter int ITER    = 4    // 1..6
) (
  input logic                  clk,
  input logic                  resetn,
  cordic_phase_demod_if.slave  bus
);

  // Two guard bits cover the CORDIC gain, one more lets -2^(IN_W-1) negate cleanly.
  localparam int XW = IN_W + 3;
  localparam int CW = 3;

  typedef enum logic {IDLE, ROTATE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [XW-1:0]      x_q, x_d;
  logic signed [XW-1:0]      y_q, y_d;
  logic signed [PHASE_W-1:0] z_q, z_d;
  logic                      zero_q, zero_d;
  logic signed [PHASE_W-1:0] prev_q, prev_d;
  logic signed [PHASE_W-1:0] phase_q, phase_d;
  logic signed [PHASE_W-1:0] freq_q, freq_d;
  logic [IN_W+1:0]           mag_q, mag_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;

  logic signed [XW-1:0]      ext_i, ext_q;
  logic signed [XW-1:0]      x_sh, y_sh;
  logic signed [XW-1:0]      x_rot, y_rot;
  logic signed [PHASE_W-1:0] z_rot, z_fin, atan_v;

  // atan(2^-i) in phase units, rounded from a 2^16-per-circle table.
  function automatic logic signed [PHASE_W-1:0] atan_rom(input logic [CW-1:0] idx);
    int fine;
    case (idx)
      3'd0:    fine = 8192;
      3'd1:    fine = 4836;
      3'd2:    fine = 2555;
      3'd3:    fine = 1297;
      3'd4:    fine = 651;
      3'd5:    fine = 326;
      default: fine = 0;
    endcase
    return PHASE_W'((fine + (1 << (15 - PHASE_W))) >>> (16 - PHASE_W));
  endfunction

  // Next-state, load/pre-rotation, micro-rotation and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    zero_d    = zero_q;
    prev_d    = prev_q;
    phase_d   = phase_q;
    freq_d    = freq_q;
    mag_d     = mag_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    ext_i  = {{(XW-IN_W){bus.I_BB[IN_W-1]}}, bus.I_BB};
    ext_q  = {{(XW-IN_W){bus.Q_BB[IN_W-1]}}, bus.Q_BB};
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_v = atan_rom(cnt_q);

    // Rotate toward the positive x axis; both updates use the pre-edge x/y.
    if (!y_q[XW-1]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_v;
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_v;
    end
    z_fin = zero_q ? '0 : z_rot;

    case (state_q)
      IDLE: begin
        if (bus.demod_iq_valid) begin
          // Left half-plane: rotate by pi first so the CORDIC only sees |angle| <= pi/2.
          if (bus.I_BB[IN_W-1]) begin
            x_d = -ext_i;
            y_d = -ext_q;
            z_d = {1'b1, {(PHASE_W-1){1'b0}}};
          end else begin
            x_d = ext_i;
            y_d = ext_q;
            z_d = '0;
          end
          zero_d  = (bus.I_BB == '0) && (bus.Q_BB == '0);
          cnt_d   = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (bus.demod_iq_valid) begin
          overrun_d = 1'b1;
        end
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          phase_d = z_fin;
          mag_d   = zero_q ? '0 : x_rot[IN_W+1:0];
          freq_d  = z_fin - prev_q;
          prev_d  = z_fin;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any in-flight sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      prev_q    <= '0;
      phase_q   <= '0;
      freq_q    <= '0;
      mag_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      zero_q    <= zero_d;
      prev_q    <= prev_d;
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      mag_q     <= mag_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.cordic_valid = valid_q;
  assign bus.phase_o      = phase_q;
  assign bus.freq_o       = freq_q;
  assign bus.mag_o        = mag_q;
  assign bus.busy_o       = (state_q == ROTATE);
  assign bus.overrun_o    = overrun_q;

endmodule

// File: tb/tb_cordic_phase_demod.sv
// tb_cordic_phase_demod: randomized and directed checks of cordic_phase_demod against an integer CORDIC model.
// Latency: n/a (bench).
// No backpressure: the bench paces samples itself.
module tb_cordic_phase_demod;

  localparam int IN_W    = 5;
  localparam int PHASE_W = 8;
  localparam int ITER    = 4;

  logic clk;
  logic resetn;

  cordic_phase_demod_if #(.IN_W(IN_W), .PHASE_W(PHASE_W)) bus ();

  cordic_phase_demod #(.IN_W(IN_W), .PHASE_W(PHASE_W), .ITER(ITER)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp;
  int n_err;
  int atan_tb [0:7];
  int model_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signed wrap of an integer angle onto the PHASE_W-bit circle.
  function automatic int wrapp(input int v);
    int m;
    int r;
    m = 1 << PHASE_W;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Vectoring CORDIC in plain integers: pre-rotate by pi for I<0, then ITER rotations.
  task automatic cordic_ref(input int i, input int q, output int ph, output int mg);
    int x;
    int y;
    int z;
    int xs;
    int ys;
    if (i == 0 && q == 0) begin
      ph = 0;
      mg = 0;
      return;
    end
    if (i < 0) begin
      x = -i; y = -q; z = -(1 << (PHASE_W - 1));
    end else begin
      x = i; y = q; z = 0;
    end
    for (int k = 0; k < ITER; k++) begin
      xs = x >>> k;
      ys = y >>> k;
      if (y >= 0) begin
        x = x + ys; y = y - xs; z = z + atan_tb[k];
      end else begin
        x = x - ys; y = y + xs; z = z - atan_tb[k];
      end
    end
    ph = wrapp(z);
    mg = x & ((1 << (IN_W + 2)) - 1);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    bus.demod_iq_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_prev = 0;
  endtask

  // Present one sample for exactly one clock; returns #1 after its accepting edge.
  task automatic issue(input int i, input int q);
    bus.I_BB = IN_W'(i);
    bus.Q_BB = IN_W'(q);
    bus.demod_iq_valid = 1'b1;
    @(posedge clk); #1;
    bus.demod_iq_valid = 1'b0;
  endtask

  // Wait a bounded number of clocks for cordic_valid; lat counts edges after the accepting edge.
  task automatic wait_result(output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.cordic_valid === 1'b1) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.I_BB = IN_W'($urandom);
      bus.Q_BB = IN_W'($urandom);
      bus.demod_iq_valid = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.cordic_valid, bus.busy_o, bus.overrun_o} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_flags: got %b want 000", {bus.cordic_valid, bus.busy_o, bus.overrun_o});
      end
    end
    n_cmp++;
    if (bus.phase_o !== '0 || bus.freq_o !== '0 || bus.mag_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: phase %0d freq %0d mag %0d want 0 0 0", bus.phase_o, bus.freq_o, bus.mag_o);
    end
    bus.demod_iq_valid = 1'b0;
    resetn = 1'b1;
    model_prev = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit got;
    int lat;
    apply_reset();
    issue(8, 0);
    n_cmp++;
    if (bus.busy_o !== 1'b1) begin
      n_err++; $display("FAIL single_busy_rise: got %b want 1", bus.busy_o);
    end
    wait_result(got, lat);
    n_cmp++;
    if (!got || lat != ITER) begin
      n_err++; $display("FAIL single_latency: got %0d (seen %0d) want %0d", lat, got, ITER);
    end
    n_cmp++;
    if (int'(bus.phase_o) != -2 || int'(bus.mag_o) != 14 || int'(bus.freq_o) != -2) begin
      n_err++;
      $display("FAIL single_result: phase %0d mag %0d freq %0d want -2 14 -2", bus.phase_o, bus.mag_o, bus.freq_o);
    end
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_err++; $display("FAIL single_busy_fall: got %b want 0", bus.busy_o);
    end
    model_prev = -2;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.cordic_valid !== 1'b0 || int'(bus.phase_o) != -2 || int'(bus.mag_o) != 14) begin
      n_err++;
      $display("FAIL single_hold: valid %b phase %0d mag %0d want 0 -2 14", bus.cordic_valid, bus.phase_o, bus.mag_o);
    end
  endtask

  // Second sample is offered at the first edge after the result, i.e. 5 clocks after the first.
  task automatic test_quadrant();
    bit got;
    int lat;
    apply_reset();
    issue(0, 8);
    wait_result(got, lat);
    n_cmp++;
    if (!got || int'(bus.phase_o) != 66 || int'(bus.mag_o) != 13 || int'(bus.freq_o) != 66) begin
      n_err++;
      $display("FAIL quad_first: seen %0d phase %0d mag %0d freq %0d want 66 13 66", got, bus.phase_o, bus.mag_o, bus.freq_o);
    end
    issue(-8, 0);
    wait_result(got, lat);
    n_cmp++;
    if (!got || lat != ITER) begin
      n_err++; $display("FAIL back_to_back_latency: got %0d (seen %0d) want %0d", lat, got, ITER);
    end
    n_cmp++;
    if (int'(bus.phase_o) != 126 || int'(bus.freq_o) != 60 || int'(bus.mag_o) != 14) begin
      n_err++;
      $display("FAIL quad_second: phase %0d freq %0d mag %0d want 126 60 14", bus.phase_o, bus.freq_o, bus.mag_o);
    end
    model_prev = 126;
  endtask

  task automatic test_zero_extreme();
    bit got;
    int lat;
    int eph;
    int emg;
    int diff;
    issue(0, 0);
    wait_result(got, lat);
    n_cmp++;
    if (!got || int'(bus.phase_o) != 0 || int'(bus.mag_o) != 0 || int'(bus.freq_o) != wrapp(0 - model_prev)) begin
      n_err++;
      $display("FAIL zero_in: seen %0d phase %0d mag %0d freq %0d want 0 0 %0d", got, bus.phase_o, bus.mag_o, bus.freq_o, wrapp(0 - model_prev));
    end
    model_prev = 0;

    issue(-16, -16);
    wait_result(got, lat);
    cordic_ref(-16, -16, eph, emg);
    n_cmp++;
    if (!got || int'(bus.phase_o) != eph || int'(bus.mag_o) != emg || int'(bus.freq_o) != wrapp(eph - model_prev)) begin
      n_err++;
      $display("FAIL extreme_neg_neg: seen %0d phase %0d mag %0d freq %0d want %0d %0d %0d", got, bus.phase_o, bus.mag_o, bus.freq_o, eph, emg, wrapp(eph - model_prev));
    end
    // Four rotations leave at most atan(1/8) (about 5 units) of residual angle.
    diff = int'(bus.phase_o) + 96;
    n_cmp++;
    if (diff > 5 || diff < -5) begin
      n_err++; $display("FAIL extreme_angle: phase %0d want within 5 of -96", bus.phase_o);
    end
    model_prev = eph;

    issue(-16, 0);
    wait_result(got, lat);
    cordic_ref(-16, 0, eph, emg);
    n_cmp++;
    if (!got || int'(bus.phase_o) != eph || int'(bus.mag_o) != emg) begin
      n_err++;
      $display("FAIL extreme_neg_axis: seen %0d phase %0d mag %0d want %0d %0d", got, bus.phase_o, bus.mag_o, eph, emg);
    end
    model_prev = eph;
  endtask

  task automatic test_random_stream();
    bit got;
    int lat;
    int si;
    int sq;
    int eph;
    int emg;
    int prev_obs;
    prev_obs = model_prev;
    for (int n = 0; n < 1000; n++) begin
      si = int'($urandom_range(0, 31)) - 16;
      sq = int'($urandom_range(0, 31)) - 16;
      issue(si, sq);
      wait_result(got, lat);
      cordic_ref(si, sq, eph, emg);
      n_cmp++;
      if (!got || int'(bus.phase_o) != eph || int'(bus.mag_o) != emg) begin
        n_err++;
        $display("FAIL stream_result[%0d] (%0d,%0d): seen %0d phase %0d mag %0d want %0d %0d", n, si, sq, got, bus.phase_o, bus.mag_o, eph, emg);
      end
      n_cmp++;
      if (int'(bus.freq_o) != wrapp(int'(bus.phase_o) - prev_obs)) begin
        n_err++;
        $display("FAIL stream_freq[%0d]: got %0d want %0d", n, bus.freq_o, wrapp(int'(bus.phase_o) - prev_obs));
      end
      prev_obs = int'(bus.phase_o);
      model_prev = eph;
    end
    n_cmp++;
    if (bus.overrun_o !== 1'b0) begin
      n_err++; $display("FAIL stream_overrun: got %b want 0", bus.overrun_o);
    end
  endtask

  task automatic test_overrun();
    int eph;
    int emg;
    int seen;
    int cph;
    int cmg;
    int cfr;
    cordic_ref(5, -3, eph, emg);
    issue(5, -3);
    @(posedge clk); #1;
    issue(-7, 9);
    seen = 0;
    cph = 0; cmg = 0; cfr = 0;
    for (int c = 0; c < 14; c++) begin
      if (bus.cordic_valid === 1'b1) begin
        if (seen == 0) begin
          cph = int'(bus.phase_o); cmg = int'(bus.mag_o); cfr = int'(bus.freq_o);
        end
        seen++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 1) begin
      n_err++; $display("FAIL overrun_count: got %0d results want 1", seen);
    end
    n_cmp++;
    if (cph != eph || cmg != emg || cfr != wrapp(eph - model_prev)) begin
      n_err++;
      $display("FAIL overrun_result: phase %0d mag %0d freq %0d want %0d %0d %0d", cph, cmg, cfr, eph, emg, wrapp(eph - model_prev));
    end
    model_prev = eph;
    n_cmp++;
    if (bus.overrun_o !== 1'b1) begin
      n_err++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(3, 4);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy_o, bus.cordic_valid, bus.overrun_o} !== 3'b000 || bus.phase_o !== '0 || bus.mag_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid_state: busy %b valid %b overrun %b phase %0d mag %0d want all 0", bus.busy_o, bus.cordic_valid, bus.overrun_o, bus.phase_o, bus.mag_o);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    model_prev = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.cordic_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL reset_mid_no_valid: got %0d results want 0", seen);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_prev = 0;
    resetn = 1'b0;
    bus.demod_iq_valid = 1'b0;
    bus.I_BB = '0;
    bus.Q_BB = '0;
    for (int k = 0; k < 8; k++) begin
      atan_tb[k] = int'($floor($atan(2.0 ** (-k)) * (2.0 ** PHASE_W) / (2.0 * 3.14159265358979) + 0.5));
    end
    test_reset();
    test_single();
    test_quadrant();
    test_zero_extreme();
    test_random_stream();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
